// File: rtl/xadc_drp_responder.sv
// xadc_drp_responder
// DRP slave that mimics the XADC register file. 0x00-0x3F hold conversion
// results and are loaded only through the sample port. 0x40-0x7F are
// configuration registers, read/write over DRP. Each DRP request is answered
// with a single drdy_out strobe a fixed number of cycles after den_in.

module xadc_drp_responder #(
    parameter int unsigned RD_LATENCY = 4,  // den_in (read) to drdy_out, 1..15
    parameter int unsigned WR_LATENCY = 2   // den_in (write) to drdy_out, 1..15
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    // DRP slave port
    input  logic [6:0]  daddr_in,
    input  logic        den_in,
    input  logic        dwe_in,
    input  logic [15:0] di_in,
    output logic [15:0] do_out,
    output logic        drdy_out,
    output logic        busy_out,
    // conversion-result load port
    input  logic        samp_valid,
    input  logic [5:0]  samp_addr,
    input  logic [15:0] samp_data,
    output logic        eoc_out,
    output logic [5:0]  channel_out,
    // status
    output logic        ovr_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // The counter is loaded with latency-1; a latency of 1 skips WAIT.
    localparam logic [3:0] RD_CNT_INIT = 4'(RD_LATENCY - 1);
    localparam logic [3:0] WR_CNT_INIT = 4'(WR_LATENCY - 1);
    localparam int         MEM_DEPTH   = 128;

    // FSM and transaction context
    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [6:0]  addr_q, addr_d;
    logic        we_q, we_d;
    logic [15:0] data_q, data_d;      // write data, or read data captured at den_in

    // Outputs held in flops
    logic [15:0] do_q, do_d;
    logic        ovr_q, ovr_d;
    logic        eoc_q, eoc_d;
    logic [5:0]  chan_q, chan_d;

    // Register file
    logic [15:0] mem_q [MEM_DEPTH];
    logic [15:0] mem_d [MEM_DEPTH];

    // Helper terms
    logic        accept;              // request taken in IDLE
    logic        enter_resp;          // first (and only) RESP cycle is next
    logic [3:0]  cnt_init;

    assign accept     = (state_q == ST_IDLE) && den_in;
    assign cnt_init   = dwe_in ? WR_CNT_INIT : RD_CNT_INIT;
    assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);

    // ------------------------------------------------------------------
    // FSM state register
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            state_q <= state_d;
        end
    end

    // FSM next-state: IDLE -> WAIT -> RESP -> IDLE, WAIT skipped for latency 1
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (den_in) begin
                    state_d = (cnt_init == 4'd0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: strobe in RESP, busy from the cycle after den_in to RESP
    always_comb begin
        drdy_out = (state_q == ST_RESP);
        busy_out = (state_q != ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Transaction context: latch request on accept, count down in WAIT
    always_comb begin
        cnt_d  = cnt_q;
        addr_d = addr_q;
        we_d   = we_q;
        data_d = data_q;
        if (accept) begin
            addr_d = daddr_in;
            we_d   = dwe_in;
            // Read data is taken from the pre-edge array, so a sample load
            // to the same address in this cycle is not seen by this read.
            data_d = dwe_in ? di_in : mem_q[daddr_in];
            cnt_d  = cnt_init;
        end else if (state_q == ST_WAIT) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Read data presented on the RESP cycle; held until the next response
    always_comb begin
        do_d = do_q;
        if (enter_resp) begin
            // Uses *_d so that a latency-1 request, which enters RESP straight
            // from IDLE, sees the request being accepted this cycle.
            do_d = we_d ? 16'h0000 : data_d;
        end
    end

    // Overrun: any request while a transaction is in flight is dropped
    always_comb begin
        ovr_d = ovr_q | (den_in && (state_q != ST_IDLE));
    end

    // Sample port handshake: eoc one cycle after a load, channel of last load
    always_comb begin
        eoc_d  = samp_valid;
        chan_d = samp_valid ? samp_addr : chan_q;
    end

    // Register file update: DRP write commit in RESP, sample loads any time
    always_comb begin
        mem_d = mem_q;
        // Result registers (addr[6]=0) are read-only from DRP; such writes
        // still complete with drdy_out but leave the array untouched.
        if ((state_q == ST_RESP) && we_q && addr_q[6]) begin
            mem_d[addr_q] = data_q;
        end
        // The two writers cover disjoint halves of the array, so they never
        // collide on one entry.
        if (samp_valid) begin
            mem_d[{1'b0, samp_addr}] = samp_data;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and status registers
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            cnt_q  <= '0;
            addr_q <= '0;
            we_q   <= 1'b0;
            data_q <= '0;
            do_q   <= '0;
            ovr_q  <= 1'b0;
            eoc_q  <= 1'b0;
            chan_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            we_q   <= we_d;
            data_q <= data_d;
            do_q   <= do_d;
            ovr_q  <= ovr_d;
            eoc_q  <= eoc_d;
            chan_q <= chan_d;
        end
    end

    // Register file storage
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            // NOTE: the array is reset because every register, results and
            // config alike, must read back as zero after reset; this forces
            // flops rather than a RAM macro.
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign do_out      = do_q;
    assign ovr_err     = ovr_q;
    assign eoc_out     = eoc_q;
    assign channel_out = chan_q;

endmodule

// File: tb/tb_xadc_drp_responder.sv
// tb_xadc_drp_responder
// Directed bench for xadc_drp_responder. Stimulus tasks push the expected
// DRP response (cycle and data) and expected eoc pulse (cycle and channel)
// into queues; a monitor on the falling edge pops and compares whenever the
// DUT strobes drdy_out or eoc_out.

module tb_xadc_drp_responder;

    localparam int RD_LAT = 4;
    localparam int WR_LAT = 2;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } rsp_t;

    typedef struct {
        int          cyc;
        logic [5:0]  chan;
    } eoc_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  daddr;
    logic        den;
    logic        dwe;
    logic [15:0] di;
    logic [15:0] do_out;
    logic        drdy_out;
    logic        busy_out;
    logic        samp_valid;
    logic [5:0]  samp_addr;
    logic [15:0] samp_data;
    logic        eoc_out;
    logic [5:0]  channel_out;
    logic        ovr_err;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    rsp_t rsp_q[$];
    eoc_t eoc_q[$];
    rsp_t mon_r;
    eoc_t mon_e;

    xadc_drp_responder #(
        .RD_LATENCY (RD_LAT),
        .WR_LATENCY (WR_LAT)
    ) dut (
        .CLK100MHZ   (clk),
        .CPU_RESETN  (rst_n),
        .daddr_in    (daddr),
        .den_in      (den),
        .dwe_in      (dwe),
        .di_in       (di),
        .do_out      (do_out),
        .drdy_out    (drdy_out),
        .busy_out    (busy_out),
        .samp_valid  (samp_valid),
        .samp_addr   (samp_addr),
        .samp_data   (samp_data),
        .eoc_out     (eoc_out),
        .channel_out (channel_out),
        .ovr_err     (ovr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every drdy/eoc strobe against the head of its queue
    always @(negedge clk) begin
        if (drdy_out) begin
            check("drdy_expected", 32'(rsp_q.size() > 0), 32'd1);
            if (rsp_q.size() > 0) begin
                mon_r = rsp_q.pop_front();
                check("drdy_cycle", cyc, mon_r.cyc);
                check("do_out", {16'h0, do_out}, {16'h0, mon_r.data});
            end
        end
        if (eoc_out) begin
            check("eoc_expected", 32'(eoc_q.size() > 0), 32'd1);
            if (eoc_q.size() > 0) begin
                mon_e = eoc_q.pop_front();
                check("eoc_cycle", cyc, mon_e.cyc);
                check("channel_out", {26'h0, channel_out}, {26'h0, mon_e.chan});
            end
        end
    end

    // All drive tasks start on a falling edge and return on the next one.
    task automatic drp(input logic [6:0] a, input logic we, input logic [15:0] d,
                       input logic [15:0] exp_rd, input bit track);
        daddr = a;
        dwe   = we;
        di    = d;
        den   = 1'b1;
        if (track) begin
            if (we) rsp_q.push_back('{cyc + WR_LAT, 16'h0000});
            else    rsp_q.push_back('{cyc + RD_LAT, exp_rd});
        end
        @(negedge clk);
        den = 1'b0;
        dwe = 1'b0;
    endtask

    task automatic samp(input logic [5:0] a, input logic [15:0] d);
        samp_valid = 1'b1;
        samp_addr  = a;
        samp_data  = d;
        eoc_q.push_back('{cyc + 1, a});
        @(negedge clk);
        samp_valid = 1'b0;
    endtask

    // Wait (bounded) until all expected strobes have been seen
    task automatic drain();
        int t = 0;
        while ((rsp_q.size() != 0 || eoc_q.size() != 0) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("drain_rsp_left", rsp_q.size(), 0);
        check("drain_eoc_left", eoc_q.size(), 0);
        rsp_q.delete();
        eoc_q.delete();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b1;
        daddr      = '0;
        den        = 1'b0;
        dwe        = 1'b0;
        di         = '0;
        samp_valid = 1'b0;
        samp_addr  = '0;
        samp_data  = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_do_out",   {16'h0, do_out}, 32'h0);
        check("rst_drdy",     {31'h0, drdy_out}, 32'h0);
        check("rst_busy",     {31'h0, busy_out}, 32'h0);
        check("rst_eoc",      {31'h0, eoc_out}, 32'h0);
        check("rst_channel",  {26'h0, channel_out}, 32'h0);
        check("rst_ovr",      {31'h0, ovr_err}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: read 0x7F after reset, busy for exactly RD_LAT cycles
        check("t1_busy_den_cycle", {31'h0, busy_out}, 32'h0);
        drp(7'h7F, 1'b0, 16'h0, 16'h0000, 1'b1);
        for (int i = 0; i < RD_LAT; i++) begin
            check("t1_busy_high", {31'h0, busy_out}, 32'h1);
            @(negedge clk);
        end
        check("t1_busy_low_after", {31'h0, busy_out}, 32'h0);
        drain();

        // 2: write 0x41=0xBEEF then read it back; do_out holds afterwards
        drp(7'h41, 1'b1, 16'hBEEF, 16'h0, 1'b1);
        drain();
        drp(7'h41, 1'b0, 16'h0, 16'hBEEF, 1'b1);
        drain();
        repeat (3) @(negedge clk);
        check("t2_do_hold", {16'h0, do_out}, 32'h0000BEEF);

        // 3: back-to-back sample loads, then DRP read of a result register
        samp(6'h03, 16'hFFF0);
        samp(6'h12, 16'h5550);
        drp(7'h03, 1'b0, 16'h0, 16'hFFF0, 1'b1);
        drain();
        check("t3_channel_hold", {26'h0, channel_out}, 32'h12);

        // 4: DRP write to a result register is acknowledged but dropped
        drp(7'h12, 1'b1, 16'h1234, 16'h0, 1'b1);
        drain();
        drp(7'h12, 1'b0, 16'h0, 16'h5550, 1'b1);
        drain();
        check("t4_ovr_still_clear", {31'h0, ovr_err}, 32'h0);

        // 5: second request two cycles into a read is ignored, ovr sticks
        drp(7'h41, 1'b0, 16'h0, 16'hBEEF, 1'b1);
        @(negedge clk);
        drp(7'h42, 1'b1, 16'h5A5A, 16'h0, 1'b0);
        check("t5_ovr_set", {31'h0, ovr_err}, 32'h1);
        drain();
        drp(7'h42, 1'b0, 16'h0, 16'h0000, 1'b1);
        drain();
        check("t5_ovr_sticky", {31'h0, ovr_err}, 32'h1);

        // 6a: read and sample load to 0x13 in the same cycle
        samp(6'h13, 16'h1110);
        daddr      = 7'h13;
        dwe        = 1'b0;
        den        = 1'b1;
        samp_valid = 1'b1;
        samp_addr  = 6'h13;
        samp_data  = 16'hAAA0;
        rsp_q.push_back('{cyc + RD_LAT, 16'h1110});
        eoc_q.push_back('{cyc + 1, 6'h13});
        @(negedge clk);
        den        = 1'b0;
        samp_valid = 1'b0;
        drain();
        drp(7'h13, 1'b0, 16'h0, 16'hAAA0, 1'b1);
        drain();

        // 6b: reset during WAIT aborts the read; no drdy after release
        drp(7'h41, 1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk);
        check("t6_in_flight", {31'h0, busy_out}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_do_out",  {16'h0, do_out}, 32'h0);
        check("t6_rst_drdy",    {31'h0, drdy_out}, 32'h0);
        check("t6_rst_busy",    {31'h0, busy_out}, 32'h0);
        check("t6_rst_eoc",     {31'h0, eoc_out}, 32'h0);
        check("t6_rst_channel", {26'h0, channel_out}, 32'h0);
        check("t6_rst_ovr",     {31'h0, ovr_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("t6_idle_after", {31'h0, busy_out}, 32'h0);
        // config register was cleared by reset
        drp(7'h41, 1'b0, 16'h0, 16'h0000, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
